// File: rtl/ysyx_25070198_fetch_if.sv
// ysyx_25070198_fetch_if: instruction-memory read channel, decode channel and commit channel of the fetch unit
interface ysyx_25070198_fetch_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
    logic        commit_valid;
    logic [31:0] commit_npc;
    logic        halt;
    logic [31:0] fetch_cnt;

    modport master (
        output araddr, arvalid, rready, out_valid, out_inst, out_pc, out_err, fetch_cnt,
        input  arready, rdata, rresp, rvalid, out_ready, commit_valid, commit_npc, halt
    );

    modport slave (
        input  araddr, arvalid, rready, out_valid, out_inst, out_pc, out_err, fetch_cnt,
        output arready, rdata, rresp, rvalid, out_ready, commit_valid, commit_npc, halt
    );
endinterface

// File: rtl/ysyx_25070198_fetch.sv
// ysyx_25070198_fetch: non-speculative multi-cycle RV32E fetch unit; access-fault reporting enabled by YSYX_25070198_FETCH_ACCESS_FAULT_EN
module ysyx_25070198_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_25070198_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, COMMIT, HALT} state_t;

    state_t      state, next;
    logic [31:0] pc, inst, inst_pc, cnt, inst_in;
    logic        err, r_hs, o_hs, c_hs;

    assign r_hs = state == WAIT && bus.rvalid;
    assign o_hs = state == OUT && bus.out_ready;
    assign c_hs = state == COMMIT && bus.commit_valid;

    // state register, synchronous active-low reset back to IDLE
    always_ff @(posedge clk) begin
        state <= !rst ? IDLE : next;
    end

    // next state: each state waits for its own handshake only
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = REQ;
            REQ:     next = bus.arready ? WAIT : REQ;
            WAIT:    next = bus.rvalid ? OUT : WAIT;
            OUT:     next = bus.out_ready ? COMMIT : OUT;
            COMMIT:  next = bus.commit_valid ? (bus.halt ? HALT : REQ) : COMMIT;
            HALT:    next = HALT;
            default: next = IDLE;
        endcase
    end

    // PC, latched instruction and handshake counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RESET_PC;
            inst    <= 32'h0;
            inst_pc <= RESET_PC;
            cnt     <= 32'h0;
        end else begin
            if (r_hs) begin
                inst    <= inst_in;
                inst_pc <= pc;
            end
            if (o_hs) cnt <= cnt + 32'd1;
            if (c_hs && !bus.halt) pc <= {bus.commit_npc[31:2], 2'b00};
        end
    end

`ifdef YSYX_25070198_FETCH_ACCESS_FAULT_EN
    assign inst_in = bus.rresp == 2'b00 ? bus.rdata : 32'h0;

    // fault flag follows the response of the most recent read
    always_ff @(posedge clk) begin
        if (!rst) err <= 1'b0;
        else if (r_hs) err <= bus.rresp != 2'b00;
    end

    logic unused;
    assign unused = ^bus.commit_npc[1:0];
`else
    assign inst_in = bus.rdata;
    assign err     = 1'b0;

    logic unused;
    assign unused = ^{bus.rresp, bus.commit_npc[1:0]};
`endif

    assign bus.araddr    = pc;
    assign bus.arvalid   = state == REQ;
    assign bus.rready    = state == WAIT;
    assign bus.out_valid = state == OUT;
    assign bus.out_inst  = inst;
    assign bus.out_pc    = inst_pc;
    assign bus.out_err   = err;
    assign bus.fetch_cnt = cnt;
endmodule

// File: tb/tb_ysyx_25070198_fetch.sv
// tb_ysyx_25070198_fetch: directed and randomized cycle-exact checks of the fetch unit against a transaction-level model
module tb_ysyx_25070198_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_cnt = 32'h0;

    ysyx_25070198_fetch_if bus ();

    ysyx_25070198_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr == RESET_PC ? 32'h0000_0413 : ({addr[15:0], ~addr[15:0]} ^ 32'h0013_0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_out_inst", bus.out_inst, 0);
        check("rst_out_pc", bus.out_pc, RESET_PC);
        check("rst_araddr", bus.araddr, RESET_PC);
        check("rst_fetch_cnt", bus.fetch_cnt, 0);
    endtask

    // One full instruction lifetime, starting at the negedge where REQ is expected.
    // Each phase lasts exactly wait+1 cycles; every cycle is checked.
    task automatic fetch(input int aw, input int rw, input int ow, input int cw,
                         input logic [31:0] npc, input logic h, input logic [1:0] resp, input logic spur);
        logic [31:0] data, ei;
        logic ee;
        data = mem_word(exp_pc);
`ifdef YSYX_25070198_FETCH_ACCESS_FAULT_EN
        ee = resp != 2'b00;
`else
        ee = 1'b0;
`endif
        ei = ee ? 32'h0 : data;
        for (int i = 0; i <= aw; i++) begin
            check("req_arvalid", bus.arvalid, 1);
            check("req_araddr", bus.araddr, exp_pc);
            check("req_rready", bus.rready, 0);
            bus.arready = i == aw;
            @(negedge clk);
        end
        bus.arready = 1'b0;
        for (int i = 0; i <= rw; i++) begin
            check("wait_rready", bus.rready, 1);
            check("wait_arvalid", bus.arvalid, 0);
            check("wait_out_valid", bus.out_valid, 0);
            check("wait_araddr", bus.araddr, exp_pc);
            bus.commit_valid = spur && i < rw;
            bus.commit_npc = 32'h1234_5677;
            bus.rvalid = i == rw;
            bus.rdata = i == rw ? data : 32'hdead_beef;
            bus.rresp = resp;
            @(negedge clk);
        end
        bus.rvalid = 1'b0;
        bus.commit_valid = 1'b0;
        for (int i = 0; i <= ow; i++) begin
            check("out_valid", bus.out_valid, 1);
            check("out_inst", bus.out_inst, ei);
            check("out_pc", bus.out_pc, exp_pc);
            check("out_err", bus.out_err, ee);
            check("out_rready", bus.rready, 0);
            bus.out_ready = i == ow;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        for (int i = 0; i <= cw; i++) begin
            check("commit_out_valid", bus.out_valid, 0);
            check("commit_arvalid", bus.arvalid, 0);
            check("commit_fetch_cnt", bus.fetch_cnt, exp_cnt);
            bus.commit_valid = i == cw;
            bus.commit_npc = npc;
            bus.halt = h;
            @(negedge clk);
        end
        bus.commit_valid = 1'b0;
        bus.halt = 1'b0;
        if (!h) exp_pc = npc & 32'hffff_fffc;
    endtask

    initial begin
        bus.arready = 1'b0;
        bus.rdata = 32'h0;
        bus.rresp = 2'b00;
        bus.rvalid = 1'b0;
        bus.out_ready = 1'b0;
        bus.commit_valid = 1'b0;
        bus.commit_npc = 32'h0;
        bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b1;
        @(negedge clk);
        fetch(0, 0, 0, 0, exp_pc + 32'd4, 1'b0, 2'b00, 1'b0);
        fetch(0, 0, 0, 0, exp_pc + 32'd4, 1'b0, 2'b00, 1'b0);
        fetch(0, 0, 0, 0, exp_pc + 32'd4, 1'b0, 2'b00, 1'b0);
        check("cnt_after_three", bus.fetch_cnt, 3);
        fetch(2, 3, 1, 0, 32'h8000_0123, 1'b0, 2'b00, 1'b0);
        check("masked_araddr", bus.araddr, 32'h8000_0120);
        fetch(0, 2, 0, 1, exp_pc + 32'd4, 1'b0, 2'b00, 1'b1);
        fetch(1, 0, 0, 0, exp_pc + 32'd4, 1'b0, 2'b10, 1'b0);
        fetch(0, 1, 0, 0, exp_pc + 32'd4, 1'b0, 2'b00, 1'b0);
        for (int k = 0; k < 40; k++)
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  RESET_PC + $urandom_range(0, 4095), 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        fetch(0, 0, 0, 2, 32'h8000_0400, 1'b1, 2'b00, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check("halt_arvalid", bus.arvalid, 0);
            check("halt_fetch_cnt", bus.fetch_cnt, exp_cnt);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        rst = 1'b1;
        exp_pc = RESET_PC;
        exp_cnt = 32'h0;
        @(negedge clk);
        fetch(0, 0, 0, 0, exp_pc + 32'd4, 1'b0, 2'b00, 1'b0);
        check("restart_araddr", bus.araddr, RESET_PC + 32'd4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
